msgpu_bus_line_frontend: RTL and testbench
==========================================

Name: msgpu_bus_line_frontend

Overview:
Front end of the MSGPU between the MCU bus and the VGA scan-out.
- Contains a programmable clock divider.
- Contains an MCU bus message broker, which captures asynchronous bus bytes into the system_clock domain as command bytes or 12-bit pixels.
- Contains a dual-port line buffer and a copy engine that fills that buffer from framebuffer memory, one line (640 pixels) per line_finished event.

Parameters:
- DATA_WIDTH, 12: pixel / line-buffer word width.
- ADDRESS_SIZE, 13: line-buffer address width (8192 words).
- FB_ADDR_WIDTH, 22: framebuffer read-pointer width.
- LINE_PIXELS, 640: pixels copied per line.

Ports:
- system_clock  in  1  sole clock; all logic is on its rising edge.
- reset_sync  in  1  reset, asynchronous, active-high.
- div  in  8  divider ratio, 1..255; a value of 0 is treated as 1.
- divided_clock  out  1  system_clock / div.
- mcu_bus_clock  in  1  asynchronous byte strobe; data is valid at its rising edge.
- mcu_bus  in  8  bus byte; input only.
- mcu_bus_command_data  in  1  1 = command byte, 0 = pixel byte.
- command_strobe  out  1  one-cycle pulse when a command byte is accepted.
- command_data  out  8  last command byte.
- pixel_strobe  out  1  one-cycle pulse when a full pixel has been assembled.
- pixel_data  out  12  last assembled pixel.
- fb_read_pointer  out  22  framebuffer read address.
- fb_read_data  in  12  framebuffer data, valid one cycle after the address.
- line_finished  in  1  asynchronous level from the VGA block; its rising edge marks end of line.
- line_read_address  in  13  scan-out read address.
- line_data  out  12  line-buffer word, registered, 1-cycle read latency.

Behaviour:
- Reset values: all outputs 0. Divider counter 0, pixel byte phase 0, copied 0, line write pointer 0, write enable 0, second_line 0.
- Clock divider:
  - Counter runs 0..div-1 and wraps to 0.
  - divided_clock is 1 while counter < div/2 (integer division), else 0.
  - div=1 gives divided_clock constantly 0. div=3 gives high 1 cycle, low 2 cycles.
  - A change of div takes effect at the next wrap.
- Broker, synchronisation:
  - mcu_bus_clock passes through a 3-flop synchroniser; a rising edge is detected from stages 2 and 3.
  - mcu_bus and mcu_bus_command_data are captured into registers when synchronised stage 1 rises. They must be held stable for at least 3 system_clock cycles.
- Broker, byte handling on each detected edge:
  - Command byte: command_data <= byte, command_strobe = 1 for exactly one cycle, pixel phase <= 0 (a partial pixel is discarded).
  - Pixel byte, phase 0: hold byte as pixel bits [11:4], phase <= 1.
  - Pixel byte, phase 1: pixel_data <= {held byte, byte[7:4]}, pixel_strobe = 1 for one cycle, phase <= 0. byte[3:0] is ignored.
  - Strobes appear 3–4 system cycles after the mcu_bus_clock edge.
- Line buffer:
  - Write is synchronous when write enable is high.
  - Read is registered. A read and write to the same address in the same cycle returns the old data.
- Copy engine:
  - While copied < LINE_PIXELS and write enable = 0 (prefetch): fb_read_pointer += 1, write enable <= 1.
  - While copied < LINE_PIXELS and write enable = 1: write fb_read_data at the line write pointer, then line write pointer += 1, fb_read_pointer += 1, copied += 1.
  - When copied == LINE_PIXELS: write enable <= 0 and the engine idles.
- Line end:
  - line_finished passes through a 2-flop synchroniser; its rising edge overrides copy activity for that cycle.
  - On the edge: copied <= 0, write enable <= 0, fb_read_pointer -= 1 (undoes the prefetch overshoot).
  - second_line toggles. When second_line was 1, the line write pointer <= 0. The buffer therefore holds two lines, at addresses 0..639 and 640..1279.
- Wrap-around: fb_read_pointer wraps modulo 2^22; the line write pointer wraps modulo 2^13.
- Reset asserted mid-copy: the engine restarts from address 0 once reset is released.

Decomposition:
- Shared package: LINE_PIXELS, default widths, and the command/pixel select encoding.
- Natural sub-module: msgpu_line_ram (dual-port RAM, DATA_WIDTH/ADDRESS_SIZE).
- Divider, broker and copy engine sit in the top module.

Test Plan:
- div=3 -> divided_clock pattern 1,0,0 repeating. div=4 -> 1,1,0,0.
- Command byte 0x02 (command_data=1) -> one command_strobe pulse, command_data=0x02, within 4 system cycles.
- Pixel bytes 0xAB then 0xC7 -> one pixel_strobe pulse, pixel_data=0xABC. A command sent between the two pixel bytes -> no pixel_strobe.
- After reset, fb_read_data = fb_read_pointer[11:0] model -> line addresses 0..639 hold 0x000..0x27F; copy completes 641 cycles after reset release; fb_read_pointer ends at 641.
- First line_finished rising edge -> fb_read_pointer=640; second line written at 640..1279. Second edge -> line write pointer returns to 0.
- reset_sync asserted at copied=300 -> all counters 0 immediately (asynchronously); copy restarts at address 0 after release.

Source files
------------

// File: rtl/msgpu_bus_line_frontend_pkg.sv
// Shared constants and types for the MSGPU bus/line front end.
package msgpu_bus_line_frontend_pkg;

  localparam int DATA_WIDTH_DEF    = 12;
  localparam int ADDRESS_SIZE_DEF  = 13;
  localparam int FB_ADDR_WIDTH_DEF = 22;
  localparam int LINE_PIXELS_DEF   = 640;

  typedef enum logic {
    BUS_SEL_PIXEL   = 1'b0,
    BUS_SEL_COMMAND = 1'b1
  } busSel_e;

  typedef enum logic {
    PHASE_HIGH_BYTE = 1'b0,
    PHASE_LOW_BYTE  = 1'b1
  } pixelPhase_e;

  // A programmed ratio of zero behaves exactly like a ratio of one.
  function automatic logic [7:0] effectiveDiv(input logic [7:0] ratio);
    return (ratio == 8'd0) ? 8'd1 : ratio;
  endfunction

endpackage

// File: rtl/msgpu_bus_line_frontend_line_ram.sv
// Dual-port line buffer: synchronous write port, registered read port.
module msgpu_line_ram #(
  parameter int DATA_WIDTH   = 12,
  parameter int ADDRESS_SIZE = 13
) (
  input  logic                    system_clock,
  input  logic                    reset_sync,
  input  logic                    writeEnable_i,
  input  logic [ADDRESS_SIZE-1:0] writeAddress_i,
  input  logic [DATA_WIDTH-1:0]   writeData_i,
  input  logic [ADDRESS_SIZE-1:0] readAddress_i,
  output logic [DATA_WIDTH-1:0]   readData_o
);

  logic [DATA_WIDTH-1:0] mem [2**ADDRESS_SIZE];
  logic [DATA_WIDTH-1:0] readData_q;

  always_ff @(posedge system_clock) begin
    if (writeEnable_i) begin
      mem[writeAddress_i] <= writeData_i;
    end
  end

  // Same-address read during a write returns the previous contents.
  always_ff @(posedge system_clock or posedge reset_sync) begin
    if (reset_sync) begin
      readData_q <= '0;
    end else begin
      readData_q <= mem[readAddress_i];
    end
  end

  assign readData_o = readData_q;

endmodule

// File: rtl/msgpu_bus_line_frontend.sv
// MSGPU front end: clock divider, MCU bus message broker and line-buffer copy engine.
module msgpu_bus_line_frontend
  import msgpu_bus_line_frontend_pkg::*;
#(
  parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int ADDRESS_SIZE  = ADDRESS_SIZE_DEF,
  parameter int FB_ADDR_WIDTH = FB_ADDR_WIDTH_DEF,
  parameter int LINE_PIXELS   = LINE_PIXELS_DEF
) (
  input  logic                     system_clock,
  input  logic                     reset_sync,
  input  logic [7:0]               div,
  output logic                     divided_clock,
  input  logic                     mcu_bus_clock,
  input  logic [7:0]               mcu_bus,
  input  logic                     mcu_bus_command_data,
  output logic                     command_strobe,
  output logic [7:0]               command_data,
  output logic                     pixel_strobe,
  output logic [DATA_WIDTH-1:0]    pixel_data,
  output logic [FB_ADDR_WIDTH-1:0] fb_read_pointer,
  input  logic [DATA_WIDTH-1:0]    fb_read_data,
  input  logic                     line_finished,
  input  logic [ADDRESS_SIZE-1:0]  line_read_address,
  output logic [DATA_WIDTH-1:0]    line_data
);

  localparam int CW = $clog2(LINE_PIXELS + 1);
  localparam logic [CW-1:0] LINE_COUNT = CW'(LINE_PIXELS);

  // ---------------- clock divider ----------------
  logic [7:0] divCount_q, divCount_d;
  logic [7:0] divActive_q, divActive_d;

  // The ratio is only sampled at the wrap so a period is never cut short.
  always_comb begin
    divCount_d  = divCount_q + 8'd1;
    divActive_d = divActive_q;
    if (divCount_q >= divActive_q - 8'd1) begin
      divCount_d  = 8'd0;
      divActive_d = effectiveDiv(div);
    end
  end

  always_ff @(posedge system_clock or posedge reset_sync) begin
    if (reset_sync) begin
      divCount_q  <= 8'd0;
      divActive_q <= 8'd1;
    end else begin
      divCount_q  <= divCount_d;
      divActive_q <= divActive_d;
    end
  end

  assign divided_clock = (divCount_q < (divActive_q >> 1));

  // ---------------- bus broker ----------------
  logic [2:0]  busClkSync_q;
  logic [7:0]  busByte_q;
  busSel_e     busSel_q;
  logic        captureNow;
  logic        busEdge;

  pixelPhase_e           phase_q, phase_d;
  logic [7:0]            heldByte_q, heldByte_d;
  logic [7:0]            commandData_q, commandData_d;
  logic                  commandStrobe_q, commandStrobe_d;
  logic [DATA_WIDTH-1:0] pixelData_q, pixelData_d;
  logic                  pixelStrobe_q, pixelStrobe_d;

  assign captureNow = busClkSync_q[0] & ~busClkSync_q[1];
  assign busEdge    = busClkSync_q[1] & ~busClkSync_q[2];

  // Bus byte is latched one stage ahead of the edge so it is stable when decoded.
  always_ff @(posedge system_clock or posedge reset_sync) begin
    if (reset_sync) begin
      busClkSync_q <= 3'b000;
      busByte_q    <= 8'd0;
      busSel_q     <= BUS_SEL_PIXEL;
    end else begin
      busClkSync_q <= {busClkSync_q[1:0], mcu_bus_clock};
      if (captureNow) begin
        busByte_q <= mcu_bus;
        busSel_q  <= busSel_e'(mcu_bus_command_data);
      end
    end
  end

  always_comb begin
    phase_d         = phase_q;
    heldByte_d      = heldByte_q;
    commandData_d   = commandData_q;
    commandStrobe_d = 1'b0;
    pixelData_d     = pixelData_q;
    pixelStrobe_d   = 1'b0;
    if (busEdge) begin
      if (busSel_q == BUS_SEL_COMMAND) begin
        commandData_d   = busByte_q;
        commandStrobe_d = 1'b1;
        phase_d         = PHASE_HIGH_BYTE;
      end else begin
        case (phase_q)
          PHASE_HIGH_BYTE: begin
            heldByte_d = busByte_q;
            phase_d    = PHASE_LOW_BYTE;
          end
          PHASE_LOW_BYTE: begin
            pixelData_d   = DATA_WIDTH'({heldByte_q, busByte_q[7:4]});
            pixelStrobe_d = 1'b1;
            phase_d       = PHASE_HIGH_BYTE;
          end
          default: phase_d = PHASE_HIGH_BYTE;
        endcase
      end
    end
  end

  always_ff @(posedge system_clock or posedge reset_sync) begin
    if (reset_sync) begin
      phase_q         <= PHASE_HIGH_BYTE;
      heldByte_q      <= 8'd0;
      commandData_q   <= 8'd0;
      commandStrobe_q <= 1'b0;
      pixelData_q     <= '0;
      pixelStrobe_q   <= 1'b0;
    end else begin
      phase_q         <= phase_d;
      heldByte_q      <= heldByte_d;
      commandData_q   <= commandData_d;
      commandStrobe_q <= commandStrobe_d;
      pixelData_q     <= pixelData_d;
      pixelStrobe_q   <= pixelStrobe_d;
    end
  end

  assign command_strobe = commandStrobe_q;
  assign command_data   = commandData_q;
  assign pixel_strobe   = pixelStrobe_q;
  assign pixel_data     = pixelData_q;

  // ---------------- copy engine ----------------
  logic [1:0]               lineSync_q;
  logic                     linePrev_q;
  logic                     lineEdge;
  logic [FB_ADDR_WIDTH-1:0] fbPtr_q, fbPtr_d;
  logic [ADDRESS_SIZE-1:0]  lineWrPtr_q, lineWrPtr_d;
  logic [CW-1:0]            copied_q, copied_d;
  logic                     writeEnable_q, writeEnable_d;
  logic                     secondLine_q, secondLine_d;
  logic                     ramWrite;

  assign lineEdge = lineSync_q[1] & ~linePrev_q;
  assign ramWrite = writeEnable_q && (copied_q < LINE_COUNT) && !lineEdge;

  // Line end wins over copying; stepping the pointer back cancels the prefetch overshoot.
  always_comb begin
    fbPtr_d       = fbPtr_q;
    lineWrPtr_d   = lineWrPtr_q;
    copied_d      = copied_q;
    writeEnable_d = writeEnable_q;
    secondLine_d  = secondLine_q;
    if (lineEdge) begin
      copied_d      = '0;
      writeEnable_d = 1'b0;
      fbPtr_d       = fbPtr_q - FB_ADDR_WIDTH'(1);
      secondLine_d  = ~secondLine_q;
      if (secondLine_q) begin
        lineWrPtr_d = '0;
      end
    end else if (copied_q < LINE_COUNT) begin
      fbPtr_d = fbPtr_q + FB_ADDR_WIDTH'(1);
      if (!writeEnable_q) begin
        writeEnable_d = 1'b1;
      end else begin
        lineWrPtr_d = lineWrPtr_q + ADDRESS_SIZE'(1);
        copied_d    = copied_q + CW'(1);
      end
    end else begin
      writeEnable_d = 1'b0;
    end
  end

  always_ff @(posedge system_clock or posedge reset_sync) begin
    if (reset_sync) begin
      lineSync_q    <= 2'b00;
      linePrev_q    <= 1'b0;
      fbPtr_q       <= '0;
      lineWrPtr_q   <= '0;
      copied_q      <= '0;
      writeEnable_q <= 1'b0;
      secondLine_q  <= 1'b0;
    end else begin
      lineSync_q    <= {lineSync_q[0], line_finished};
      linePrev_q    <= lineSync_q[1];
      fbPtr_q       <= fbPtr_d;
      lineWrPtr_q   <= lineWrPtr_d;
      copied_q      <= copied_d;
      writeEnable_q <= writeEnable_d;
      secondLine_q  <= secondLine_d;
    end
  end

  assign fb_read_pointer = fbPtr_q;

  msgpu_line_ram #(
    .DATA_WIDTH  (DATA_WIDTH),
    .ADDRESS_SIZE(ADDRESS_SIZE)
  ) lineRam (
    .system_clock  (system_clock),
    .reset_sync    (reset_sync),
    .writeEnable_i (ramWrite),
    .writeAddress_i(lineWrPtr_q),
    .writeData_i   (fb_read_data),
    .readAddress_i (line_read_address),
    .readData_o    (line_data)
  );

endmodule

// File: tb/tb_msgpu_bus_line_frontend.sv
// Self-checking bench for msgpu_bus_line_frontend: divider, bus broker scoreboard and line copy.
module tb_msgpu_bus_line_frontend;

  logic        system_clock = 1'b0;
  logic        reset_sync;
  logic [7:0]  div;
  logic        divided_clock;
  logic        mcu_bus_clock;
  logic [7:0]  mcu_bus;
  logic        mcu_bus_command_data;
  logic        command_strobe;
  logic [7:0]  command_data;
  logic        pixel_strobe;
  logic [11:0] pixel_data;
  logic [21:0] fb_read_pointer;
  logic [11:0] fb_read_data = 12'd0;
  logic        line_finished;
  logic [12:0] line_read_address;
  logic [11:0] line_data;

  typedef struct packed {
    logic        isCmd;
    logic [11:0] value;
  } busExp_t;

  busExp_t    expQ[$];
  busExp_t    monEntry;
  int         testsRun = 0;
  int         testsFailed = 0;
  logic       modelPhase;
  logic [7:0] modelHeld;

  msgpu_bus_line_frontend dut (
    .system_clock        (system_clock),
    .reset_sync          (reset_sync),
    .div                 (div),
    .divided_clock       (divided_clock),
    .mcu_bus_clock       (mcu_bus_clock),
    .mcu_bus             (mcu_bus),
    .mcu_bus_command_data(mcu_bus_command_data),
    .command_strobe      (command_strobe),
    .command_data        (command_data),
    .pixel_strobe        (pixel_strobe),
    .pixel_data          (pixel_data),
    .fb_read_pointer     (fb_read_pointer),
    .fb_read_data        (fb_read_data),
    .line_finished       (line_finished),
    .line_read_address   (line_read_address),
    .line_data           (line_data)
  );

  always #5 system_clock = ~system_clock;

  // Framebuffer model: data is the low 12 address bits, one cycle after the address.
  always @(posedge system_clock) fb_read_data <= fb_read_pointer[11:0];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Every strobe must match the oldest outstanding expectation.
  always @(negedge system_clock) begin
    if (!reset_sync && (command_strobe || pixel_strobe)) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpectedStrobe", {30'd0, command_strobe, pixel_strobe}, 32'd0);
      end else begin
        monEntry = expQ.pop_front();
        checkOutput("strobeKind", 32'(command_strobe), 32'(monEntry.isCmd));
        if (monEntry.isCmd)
          checkOutput("cmdData", 32'(command_data), 32'(monEntry.value));
        else
          checkOutput("pixelData", 32'(pixel_data), 32'(monEntry.value));
      end
    end
  end

  task automatic applyStimulus(input logic isCmd, input logic [7:0] busByte);
    busExp_t e;
    logic    expectStrobe;
    int      lat;
    expectStrobe = 1'b0;
    if (isCmd) begin
      e.isCmd = 1'b1;
      e.value = {4'h0, busByte};
      expQ.push_back(e);
      modelPhase   = 1'b0;
      expectStrobe = 1'b1;
    end else if (!modelPhase) begin
      modelHeld  = busByte;
      modelPhase = 1'b1;
    end else begin
      e.isCmd = 1'b0;
      e.value = {modelHeld, busByte[7:4]};
      expQ.push_back(e);
      modelPhase   = 1'b0;
      expectStrobe = 1'b1;
    end
    @(negedge system_clock);
    mcu_bus              = busByte;
    mcu_bus_command_data = isCmd;
    mcu_bus_clock        = 1'b1;
    lat = 0;
    if (expectStrobe) begin
      do begin
        @(negedge system_clock);
        lat++;
      end while (lat < 8 && !(command_strobe || pixel_strobe));
      checkOutput("strobeLatency", 32'(lat >= 3 && lat <= 4), 32'd1);
    end else begin
      repeat (6) @(negedge system_clock);
    end
    mcu_bus_clock = 1'b0;
    repeat (5) @(negedge system_clock);
  endtask

  task automatic checkDivPattern(input int d, input int cycles);
    logic prev;
    logic found;
    found = 1'b0;
    prev  = divided_clock;
    for (int k = 0; k < 40; k++) begin
      @(negedge system_clock);
      if (!prev && divided_clock) begin
        found = 1'b1;
        break;
      end
      prev = divided_clock;
    end
    checkOutput("divRise", 32'(found), 32'd1);
    for (int i = 0; i < cycles; i++) begin
      checkOutput($sformatf("divPattern%0d_%0d", d, i), 32'(divided_clock), 32'((i % d) < (d / 2)));
      @(negedge system_clock);
    end
  endtask

  task automatic waitPointer(input int target, input int bound);
    logic found;
    found = 1'b0;
    for (int k = 0; k < bound; k++) begin
      @(negedge system_clock);
      if (fb_read_pointer == 22'(target)) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput($sformatf("lineEdgePtr%0d", target), 32'(found), 32'd1);
  endtask

  task automatic checkLine(input int base, input int count, input int dataBase);
    for (int i = 0; i < count; i++) begin
      line_read_address = 13'(base + i);
      @(negedge system_clock);
      checkOutput($sformatf("lineData@%0d", base + i), 32'(line_data), 32'((dataBase + i) & 12'hFFF));
    end
  endtask

  initial begin
    reset_sync           = 1'b1;
    div                  = 8'd3;
    mcu_bus_clock        = 1'b0;
    mcu_bus              = 8'd0;
    mcu_bus_command_data = 1'b0;
    line_finished        = 1'b0;
    line_read_address    = 13'd0;
    modelPhase           = 1'b0;
    modelHeld            = 8'd0;

    repeat (3) @(negedge system_clock);
    checkOutput("rstDivClk", 32'(divided_clock), 32'd0);
    checkOutput("rstCmdStrobe", 32'(command_strobe), 32'd0);
    checkOutput("rstCmdData", 32'(command_data), 32'd0);
    checkOutput("rstPixStrobe", 32'(pixel_strobe), 32'd0);
    checkOutput("rstPixData", 32'(pixel_data), 32'd0);
    checkOutput("rstFbPtr", 32'(fb_read_pointer), 32'd0);
    checkOutput("rstLineData", 32'(line_data), 32'd0);

    reset_sync = 1'b0;
    repeat (640) @(negedge system_clock);
    checkOutput("copyPtr640", 32'(fb_read_pointer), 32'd640);
    @(negedge system_clock);
    checkOutput("copyPtr641", 32'(fb_read_pointer), 32'd641);
    repeat (60) @(negedge system_clock);
    checkOutput("copyIdlePtr", 32'(fb_read_pointer), 32'd641);
    checkLine(0, 640, 0);

    checkDivPattern(3, 6);
    div = 8'd4;
    checkDivPattern(4, 8);
    div = 8'd1;
    repeat (10) @(negedge system_clock);
    for (int i = 0; i < 8; i++) begin
      checkOutput("divOneLow", 32'(divided_clock), 32'd0);
      @(negedge system_clock);
    end
    div = 8'd0;
    repeat (10) @(negedge system_clock);
    for (int i = 0; i < 8; i++) begin
      checkOutput("divZeroLow", 32'(divided_clock), 32'd0);
      @(negedge system_clock);
    end
    div = 8'd2;
    checkDivPattern(2, 6);

    applyStimulus(1'b1, 8'h02);
    applyStimulus(1'b0, 8'hAB);
    applyStimulus(1'b0, 8'hC7);
    applyStimulus(1'b0, 8'h12);
    applyStimulus(1'b1, 8'h55);
    applyStimulus(1'b0, 8'h34);
    applyStimulus(1'b0, 8'h56);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 8'($urandom));
      applyStimulus(1'b0, 8'($urandom));
    end

    line_finished = 1'b1;
    waitPointer(640, 8);
    repeat (700) @(negedge system_clock);
    checkOutput("line2Ptr", 32'(fb_read_pointer), 32'd1281);
    checkLine(640, 640, 640);
    checkLine(0, 640, 0);
    line_finished = 1'b0;
    repeat (5) @(negedge system_clock);
    line_finished = 1'b1;
    waitPointer(1280, 8);
    repeat (700) @(negedge system_clock);
    checkOutput("line3Ptr", 32'(fb_read_pointer), 32'd1921);
    checkLine(0, 640, 1280);
    checkLine(640, 640, 640);
    line_finished = 1'b0;
    repeat (5) @(negedge system_clock);

    reset_sync = 1'b1;
    repeat (2) @(negedge system_clock);
    reset_sync = 1'b0;
    repeat (301) @(negedge system_clock);
    checkOutput("midCopyPtr", 32'(fb_read_pointer), 32'd301);
    reset_sync = 1'b1;
    #1;
    checkOutput("asyncRstPtr", 32'(fb_read_pointer), 32'd0);
    checkOutput("asyncRstLineData", 32'(line_data), 32'd0);
    checkOutput("asyncRstDivClk", 32'(divided_clock), 32'd0);
    repeat (2) @(negedge system_clock);
    reset_sync = 1'b0;
    repeat (641) @(negedge system_clock);
    checkOutput("restartPtr", 32'(fb_read_pointer), 32'd641);
    checkLine(0, 640, 0);

    checkOutput("scoreboardEmpty", 32'(expQ.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
